// File: rtl/multi_channel_support_unit.sv
// Multi-channel support-vertex store: NUM_CHANNELS channels x NUM_CONTEXTS contexts
// with per-entry valid bits, per-channel bypass and an adaptive context window.
module multi_channel_support_unit #(
  parameter int ADDRESS_WIDTH = 6,
  parameter int NUM_CONTEXTS  = 4,
  parameter int NUM_CHANNELS  = 4,
  parameter int STAGE_WIDTH   = 3,
  // Defaults track the project stage encodings; override if those change.
  parameter logic [STAGE_WIDTH-1:0] STAGE_IDLE         = STAGE_WIDTH'(0),
  parameter logic [STAGE_WIDTH-1:0] STAGE_RESET_ROOTS  = STAGE_WIDTH'(6),
  parameter logic [STAGE_WIDTH-1:0] STAGE_WRITE_TO_MEM = STAGE_WIDTH'(7),
  localparam int EXPOSED_DATA_SIZE = ADDRESS_WIDTH + 3
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [STAGE_WIDTH-1:0]                    global_stage,
  input  logic [NUM_CHANNELS*EXPOSED_DATA_SIZE-1:0] input_data,
  input  logic [NUM_CHANNELS-1:0]                   do_not_store,
  output logic [NUM_CHANNELS*EXPOSED_DATA_SIZE-1:0] output_data,
  output logic [NUM_CHANNELS-1:0]                   stale_read
);

  localparam int E     = EXPOSED_DATA_SIZE;
  localparam int PTR_W = $clog2(NUM_CONTEXTS);
  localparam logic [PTR_W-1:0] CTX_HALF = PTR_W'(NUM_CONTEXTS / 2);
  localparam logic [PTR_W-1:0] CTX_LAST = PTR_W'(NUM_CONTEXTS - 1);

  typedef enum logic [1:0] {
    WIN_LO   = 2'd0,
    WIN_HI   = 2'd1,
    WIN_FULL = 2'd2
  } win_t;

  logic [STAGE_WIDTH-1:0] stage, last_stage;
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [PTR_W-1:0]       ctx_min, ctx_max;
  win_t                   win_q, win_d;
  logic                   not_first, not_first_d;
  logic [E-1:0]           mem [NUM_CHANNELS][NUM_CONTEXTS];
  logic [NUM_CONTEXTS-1:0] valid [NUM_CHANNELS];
  logic                   write_stage, advance, rr_entry;

  assign write_stage = (stage == STAGE_WRITE_TO_MEM);
  assign advance     = write_stage && !(&do_not_store);
  assign rr_entry    = (stage == STAGE_RESET_ROOTS) && (last_stage != STAGE_RESET_ROOTS);

  // Two contexts cannot form a half window, so the pointers just toggle.
  function automatic logic [PTR_W-1:0] step_ptr(input logic [PTR_W-1:0] p,
                                                input logic [PTR_W-1:0] lo,
                                                input logic [PTR_W-1:0] hi);
    if (NUM_CONTEXTS == 2) return ~p;
    return (p < hi) ? p + PTR_W'(1) : lo;
  endfunction

  always_comb begin
    ctx_min = '0;
    ctx_max = CTX_LAST;
    case (win_q)
      WIN_LO:  ctx_max = CTX_HALF - PTR_W'(1);
      WIN_HI:  ctx_min = CTX_HALF;
      default: ;
    endcase
  end

  // NOTE: every always_comb output gets a default first so no path holds a value (no latch).
  always_comb begin
    win_d       = win_q;
    not_first_d = not_first;
    if (rr_entry && (wr_ptr == '0 || wr_ptr == CTX_HALF)) begin
      if (!not_first) begin
        win_d       = WIN_HI;
        not_first_d = 1'b1;
      end else if (win_q == WIN_FULL) begin
        win_d = (wr_ptr == '0) ? WIN_HI : WIN_LO;
      end else begin
        win_d = WIN_FULL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      win_q     <= WIN_LO;
      not_first <= 1'b0;
    end else begin
      win_q     <= win_d;
      not_first <= not_first_d;
    end
  end

  // NOTE: non-blocking reads of mem/valid see start-of-cycle contents, which gives
  // read-before-write even when rd_ptr == wr_ptr.
  always_ff @(posedge clk) begin
    if (reset) begin
      stage       <= STAGE_IDLE;
      last_stage  <= STAGE_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= PTR_W'(1);
      output_data <= '0;
      stale_read  <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++) valid[c] <= '0;
    end else begin
      stage      <= global_stage;
      last_stage <= stage;
      if (advance) begin
        wr_ptr <= step_ptr(wr_ptr, ctx_min, ctx_max);
        rd_ptr <= step_ptr(rd_ptr, ctx_min, ctx_max);
      end
      if (write_stage) begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
          if (do_not_store[c]) begin
            output_data[c*E +: E] <= input_data[c*E +: E];
            stale_read[c]         <= 1'b0;
            if (advance) valid[c][wr_ptr] <= 1'b0;
          end else begin
            output_data[c*E +: E] <= valid[c][rd_ptr] ? mem[c][rd_ptr] : '0;
            stale_read[c]         <= !valid[c][rd_ptr];
            valid[c][wr_ptr]      <= 1'b1;
          end
        end
      end
    end
  end

  // NOTE: data storage is deliberately not reset; the valid bits mark what is meaningful.
  always_ff @(posedge clk) begin
    if (advance) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (!do_not_store[c]) mem[c][wr_ptr] <= input_data[c*E +: E];
      end
    end
  end

endmodule

// File: tb/tb_multi_channel_support_unit.sv
// Directed bench for multi_channel_support_unit (4 contexts, 2 channels) with a
// behavioural context-store model compared on every cycle.
module tb_multi_channel_support_unit;

  localparam int E    = 9;
  localparam int NCH  = 2;
  localparam int NCTX = 4;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RR   = 3'd6;
  localparam logic [2:0] S_WR   = 3'd7;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [2:0]      global_stage = S_IDLE;
  logic [NCH*E-1:0] input_data = '0;
  logic [NCH-1:0]  do_not_store = '0;
  logic [NCH*E-1:0] output_data;
  logic [NCH-1:0]  stale_read;

  int n_checks = 0;
  int n_err    = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  multi_channel_support_unit #(
    .ADDRESS_WIDTH(6), .NUM_CONTEXTS(NCTX), .NUM_CHANNELS(NCH), .STAGE_WIDTH(3),
    .STAGE_IDLE(S_IDLE), .STAGE_RESET_ROOTS(S_RR), .STAGE_WRITE_TO_MEM(S_WR)
  ) dut (
    .clk(clk), .reset(reset), .global_stage(global_stage), .input_data(input_data),
    .do_not_store(do_not_store), .output_data(output_data), .stale_read(stale_read)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: contexts as int-indexed arrays, window as an int (0 lo, 1 hi, 2 full).
  logic [2:0]   m_stage, m_last;
  int           m_wr, m_rd, m_win;
  bit           m_nf;
  logic [E-1:0] m_mem [NCH][NCTX];
  bit           m_valid [NCH][NCTX];
  logic [E-1:0] m_out [NCH];
  bit           m_stale [NCH];

  always @(posedge clk) begin
    int lo, hi;
    bit adv, rr;
    if (reset) begin
      m_stage = S_IDLE; m_last = S_IDLE;
      m_wr = 0; m_rd = 1; m_win = 0; m_nf = 0;
      for (int c = 0; c < NCH; c++) begin
        m_out[c] = '0; m_stale[c] = 0;
        for (int k = 0; k < NCTX; k++) m_valid[c][k] = 0;
      end
    end else begin
      lo  = (m_win == 1) ? NCTX / 2 : 0;
      hi  = (m_win == 0) ? NCTX / 2 - 1 : NCTX - 1;
      adv = (m_stage == S_WR) && (do_not_store != 2'b11);
      rr  = (m_stage == S_RR) && (m_last != S_RR);
      if (m_stage == S_WR) begin
        for (int c = 0; c < NCH; c++) begin
          if (do_not_store[c]) begin
            m_out[c] = input_data[c*E +: E];
            m_stale[c] = 0;
            if (adv) m_valid[c][m_wr] = 0;
          end else begin
            m_stale[c] = !m_valid[c][m_rd];
            m_out[c] = m_stale[c] ? '0 : m_mem[c][m_rd];
            m_mem[c][m_wr] = input_data[c*E +: E];
            m_valid[c][m_wr] = 1;
          end
        end
      end
      if (rr && (m_wr == 0 || m_wr == NCTX / 2)) begin
        if (!m_nf) begin m_win = 1; m_nf = 1; end
        else if (m_win == 2) m_win = (m_wr == 0) ? 1 : 0;
        else m_win = 2;
      end
      if (adv) begin
        m_wr = (m_wr < hi) ? m_wr + 1 : lo;
        m_rd = (m_rd < hi) ? m_rd + 1 : lo;
      end
      m_last  = m_stage;
      m_stage = global_stage;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_out",   32'(output_data), 32'({m_out[1], m_out[0]}));
      check("model_stale", 32'(stale_read),  32'({m_stale[1], m_stale[0]}));
      check("model_wr",    32'(dut.wr_ptr),  32'(m_wr));
      check("model_rd",    32'(dut.rd_ptr),  32'(m_rd));
      check("model_win",   32'(dut.win_q),   32'(m_win));
    end
  end

  task automatic start_write();
    global_stage = S_WR;
    @(negedge clk);
  endtask

  task automatic write_cycle(input logic [1:0] dns, input logic [E-1:0] d0,
                             input logic [E-1:0] d1, input bit more);
    do_not_store = dns;
    input_data   = {d1, d0};
    global_stage = more ? S_WR : S_IDLE;
    @(negedge clk);
  endtask

  task automatic rr_hold(input int n);
    global_stage = S_RR;
    repeat (n) @(negedge clk);
    global_stage = S_IDLE;
    @(negedge clk);
  endtask

  task automatic check_ptrs(input string name, input int wr, input int rd);
    check({name, "_wr"}, 32'(dut.wr_ptr), 32'(wr));
    check({name, "_rd"}, 32'(dut.rd_ptr), 32'(rd));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  logic [E-1:0] bp_tab [3][2] = '{'{9'h101, 9'h1FF}, '{9'h0C3, 9'h07E}, '{9'h1E1, 9'h0AB}};

  initial begin
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    check("reset_out", 32'(output_data), 0);
    check("reset_stale", 32'(stale_read), 0);
    check_ptrs("reset", 0, 1);
    check("reset_win", 32'(dut.win_q), 0);
    reset = 1'b0;
    @(negedge clk);

    // Stale first read, then swap.
    start_write();
    write_cycle(2'b00, 9'h1A5, 9'h0F3, 1'b1);
    check("first_out", 32'(output_data), 0);
    check("first_stale", 32'(stale_read), 32'h3);
    check_ptrs("first", 1, 0);
    write_cycle(2'b00, 9'h022, 9'h044, 1'b0);
    check("swap_out", 32'(output_data), 32'({9'h0F3, 9'h1A5}));
    check("swap_stale", 32'(stale_read), 0);
    check_ptrs("swap", 0, 1);

    // Channel 1 bypasses; its context entry becomes invalid.
    start_write();
    write_cycle(2'b10, 9'h0AA, 9'h155, 1'b1);
    check("bypass_out", 32'(output_data), 32'({9'h155, 9'h022}));
    check("bypass_stale", 32'(stale_read), 0);
    check_ptrs("bypass", 1, 0);
    write_cycle(2'b00, 9'h011, 9'h033, 1'b0);
    check("cleared_out", 32'(output_data), 32'({9'h000, 9'h0AA}));
    check("cleared_stale", 32'(stale_read), 32'h2);
    check_ptrs("cleared", 0, 1);

    // All channels bypass: pointers hold.
    start_write();
    for (int i = 0; i < 3; i++) begin
      write_cycle(2'b11, bp_tab[i][0], bp_tab[i][1], i < 2);
      check("allbyp_out", 32'(output_data), 32'({bp_tab[i][1], bp_tab[i][0]}));
      check("allbyp_stale", 32'(stale_read), 0);
      check_ptrs("allbyp", 0, 1);
    end

    // Window: first entry (held 4 cycles) -> HI, then wrap 3->2.
    rr_hold(4);
    check("win_hi", 32'(dut.win_q), 1);
    start_write();
    for (int i = 0; i < 4; i++) write_cycle(2'b00, 9'(i * 37 + 5), 9'(i * 11 + 3), i < 3);
    check_ptrs("hi_wrap", 2, 3);
    rr_hold(2);
    check("win_full", 32'(dut.win_q), 2);
    start_write();
    for (int i = 0; i < 4; i++) begin
      write_cycle(2'b00, 9'(i * 53 + 9), 9'(i * 29 + 1), i < 3);
      if (i == 1) check_ptrs("full_wrap", 0, 1);
    end
    check_ptrs("full_end", 2, 3);
    rr_hold(2);
    check("win_lo", 32'(dut.win_q), 0);
    start_write();
    write_cycle(2'b00, 9'h0E7, 9'h17C, 1'b1);
    check_ptrs("lo_wrap", 0, 0);
    write_cycle(2'b00, 9'h033, 9'h0C0, 1'b0);
    check_ptrs("lo_next", 1, 1);
    rr_hold(2);
    check("win_hold", 32'(dut.win_q), 0);

    // Reset in the middle of a write burst.
    start_write();
    write_cycle(2'b00, 9'h111, 9'h122, 1'b1);
    write_cycle(2'b00, 9'h133, 9'h144, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_out", 32'(output_data), 0);
    check("midrst_stale", 32'(stale_read), 0);
    check_ptrs("midrst", 0, 1);
    check("midrst_win", 32'(dut.win_q), 0);
    reset = 1'b0;
    start_write();
    write_cycle(2'b00, 9'h155, 9'h166, 1'b0);
    check("post_rst_stale", 32'(stale_read), 32'h3);
    check("post_rst_out", 32'(output_data), 0);
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/multi_channel_support_unit.md
# multi_channel_support_unit

Parametrised successor to the single-vertex support PE. It holds the exposed state of `NUM_CHANNELS` missing boundary vertices across `NUM_CONTEXTS` decoding contexts. Each channel has its own per-channel bypass, and every stored entry carries a valid bit, so reads of never-written contexts are detectable. The context window adapts between half-range and full-range once per `STAGE_RESET_ROOTS` entry. The block sits beside the boundary PEs and is stage-driven by the global controller.

## Interface
- `ADDRESS_WIDTH`, 6: vertex address width. `EXPOSED_DATA_SIZE = ADDRESS_WIDTH+3`.
- `NUM_CONTEXTS`, 4: contexts per channel. Power of two, ≥2. `H = NUM_CONTEXTS/2`.
- `NUM_CHANNELS`, 4: independent support vertices.
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `global_stage`, in, `STAGE_WIDTH`: controller stage, using the encodings in `parameters.sv`.
- `input_data`, in, `NUM_CHANNELS*EXPOSED_DATA_SIZE`: channel c occupies bits `[c*E +: E]`.
- `do_not_store`, in, `NUM_CHANNELS`: per-channel bypass.
- `output_data`, out, `NUM_CHANNELS*EXPOSED_DATA_SIZE`: registered. Same packing as `input_data`.
- `stale_read`, out, `NUM_CHANNELS`: registered. 1 means the last output for that channel came from an invalid entry.

## Operation
- **Stage tracking.**
  - `stage <= global_stage` and `last_stage <= stage`. Both reset to `STAGE_IDLE`.
  - All behaviour below keys on the registered `stage`.
  - `rr_entry = (stage==STAGE_RESET_ROOTS && last_stage!=STAGE_RESET_ROOTS)`.
- **Storage.**
  - Per channel: `NUM_CONTEXTS` × `EXPOSED_DATA_SIZE` data entries plus `NUM_CONTEXTS` valid bits.
  - Valid bits reset to 0. Data contents are unspecified after reset.
- **Pointers.**
  - `wr_ptr` and `rd_ptr` are shared by all channels, each `log2(NUM_CONTEXTS)` bits. Reset values: `wr_ptr=0`, `rd_ptr=1`.
  - `advance = (stage==STAGE_WRITE_TO_MEM) && !(&do_not_store)`.
  - On `advance`, each pointer steps as `ptr<ctx_max ? ptr+1 : ctx_min`.
  - When `NUM_CONTEXTS==2`, each pointer simply inverts.
- **Write cycle** (`stage==STAGE_WRITE_TO_MEM`), per channel c:
  - If `do_not_store[c]==0` and `advance`:
    - Write `mem[c][wr_ptr]` with `input_data[c]` and set `valid[c][wr_ptr]=1`.
    - `output_data[c] <=` the value of `mem[c][rd_ptr]` as it stood at the start of the cycle. This is read-before-write, including when `rd_ptr==wr_ptr`.
    - `stale_read[c] <= !valid[c][rd_ptr]`.
    - When the entry is stale, `output_data[c]` is forced to 0.
  - If `do_not_store[c]==1`:
    - `output_data[c] <= input_data[c]` and `stale_read[c] <= 0`.
    - If `advance` is high, clear `valid[c][wr_ptr]`, because the context moves on without this channel.
  - If every channel has `do_not_store=1`: every channel bypasses, the pointers hold and no valid bit changes.
- **Outside the write stage**, `output_data` and `stale_read` hold their values.
- **Window FSM.**
  - States: `WIN_LO` = [0, H-1] (reset state), `WIN_HI` = [H, N-1], `WIN_FULL` = [0, N-1]. Flag `not_first` resets to 0.
  - Transitions are evaluated only on `rr_entry` with `wr_ptr ∈ {0, H}`:
    - `!not_first`: go to `WIN_HI` and set `not_first`.
    - From `WIN_FULL`: go to `WIN_HI` if `wr_ptr==0`, else `WIN_LO`.
    - From `WIN_LO` or `WIN_HI`: go to `WIN_FULL`.
  - A multi-cycle `STAGE_RESET_ROOTS` transitions once only.
  - If `wr_ptr` is not 0 or H at `rr_entry`, the state is unchanged.
- **Reset mid-operation.** Pointers, window state, valid bits, outputs and the stage registers all return to their reset values on the next edge.

## Timing
- `global_stage` → `stage`: 1 cycle.
- `output_data` and `stale_read` update on the edge ending a `stage==STAGE_WRITE_TO_MEM` cycle.
  - Total latency from `global_stage` to output: 2 edges.
- Pointer and valid-bit updates land on the same edge as the output update. A following write cycle sees the new pointers.
- Window update lands on the edge ending the `rr_entry` cycle. It affects pointer wrap from the next advance.
- Reset values: `output_data=0`, `stale_read=0`.

## Test plan
- **Stale first read.** Reset; `N=4`, `C=2`, one write cycle with both channels storing ch0=0x1A5, ch1=0x0F3. Required: `wr_ptr=1`, `rd_ptr=0`, `output_data=0`, `stale_read=2'b11`.
- **Swap.** Continue with a second write of 0x022/0x044. Required: output ch0=0x1A5, ch1=0x0F3; `stale_read=0`; `wr_ptr=0`, `rd_ptr=1`.
- **Per-channel bypass.** `do_not_store=2'b10` with ch1 input 0x155. Required: ch1 output is 0x155 on the next edge; ch0 follows the store path; `valid[1][old wr_ptr]` is cleared; both pointers advance.
- **All bypass.** `do_not_store=2'b11` for 3 write cycles. Required: outputs equal the inputs each cycle; `wr_ptr` and `rd_ptr` unchanged.
- **Window sequence.**
  - `STAGE_RESET_ROOTS` held 4 cycles at `wr_ptr=0`: window goes to `WIN_HI` once.
  - Next entry: `WIN_FULL`.
  - Next entry at `wr_ptr=2`: `WIN_LO`.
  - Check pointer wrap in each window, e.g. `WIN_HI` wraps 3→2.
- **Reset mid-write.** Assert `reset` during a `STAGE_WRITE_TO_MEM` burst. Required on the next edge: outputs=0, `wr_ptr=0`, `rd_ptr=1`, `WIN_LO`. The first subsequent write reports `stale_read=all ones`.
